// File: rtl/scr1_imem_responder.sv
// SCR1 imem target endpoint: serves reads from a pipelined read-only backend and
// answers writes, misaligned and out-of-window accesses locally with an error.
module scr1_imem_responder #(
  parameter logic [31:0] SCR1_ADDR_MASK    = 32'hffff0000,
  parameter logic [31:0] SCR1_ADDR_PATTERN = 32'h00010000,
  parameter int unsigned OUTSTANDING       = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_ack,
  input  logic        imem_req,
  input  logic        imem_cmd,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic [1:0]  imem_resp,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  output logic        proto_err
);

  localparam int unsigned CW = $clog2(OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(OUTSTANDING);

  logic [CW-1:0] cnt;
  logic          err_pend;
  logic          lerr;
  logic          room;
  logic          retire;
  logic          be_ack;
  logic          err_ack;

  assign mem_addr = imem_addr;

  always_comb begin
    lerr    = imem_cmd | (|imem_addr[1:0]) |
              ((imem_addr & SCR1_ADDR_MASK) != SCR1_ADDR_PATTERN);
    retire  = mem_rvalid & (cnt != '0);
    // A retire in the same cycle frees the slot for a new backend read.
    room    = (cnt < MAX_CNT) | ((cnt == MAX_CNT) & mem_rvalid);
    mem_req = imem_req & ~lerr & ~err_pend & room & ~rst;
    be_ack  = mem_req & mem_gnt;
    // Local errors wait for the backend pipe to drain so responses stay ordered.
    err_ack = imem_req & lerr & ~err_pend & (cnt == '0) & ~mem_rvalid & ~rst;
    imem_req_ack = be_ack | err_ack;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      err_pend   <= 1'b0;
      imem_resp  <= 2'b00;
      imem_rdata <= '0;
      proto_err  <= 1'b0;
    end else begin
      cnt <= cnt + CW'(be_ack) - CW'(retire);
      if (retire) begin
        imem_resp  <= mem_err ? 2'b10 : 2'b01;
        imem_rdata <= mem_err ? '0 : mem_rdata;
      end else if (err_pend) begin
        imem_resp  <= 2'b10;
        imem_rdata <= '0;
        err_pend   <= 1'b0;
      end else begin
        imem_resp  <= 2'b00;
      end
      if (err_ack) begin
        err_pend <= 1'b1;
      end
      if (mem_rvalid && (cnt == '0)) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scr1_imem_responder.sv
// Bench for scr1_imem_responder: directed vector table, then random traffic
// against a queue-based model of the imem protocol and an in-order backend.
module tb_scr1_imem_responder;

  localparam logic [31:0] MASK = 32'hffff0000;
  localparam logic [31:0] PAT  = 32'h00010000;
  localparam int OUTS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_ack;
  logic        imem_req;
  logic        imem_cmd;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_resp;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        proto_err;

  scr1_imem_responder #(
    .SCR1_ADDR_MASK   (MASK),
    .SCR1_ADDR_PATTERN(PAT),
    .OUTSTANDING      (OUTS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req_ack(imem_req_ack),
    .imem_req    (imem_req),
    .imem_cmd    (imem_cmd),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_resp   (imem_resp),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .mem_err     (mem_err),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic        req, cmd;
    logic [31:0] addr;
    logic        gnt, rv;
    logic [31:0] rd;
    logic        er;
    logic        ack, mr;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        proto;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input logic req, cmd, input logic [31:0] addr, input logic gnt, rv,
                   input logic [31:0] rd, input logic er, input logic ack, mr,
                   input logic [1:0] resp, input logic [31:0] rdata, input logic proto);
    vec_t e;
    e.req = req; e.cmd = cmd; e.addr = addr; e.gnt = gnt; e.rv = rv; e.rd = rd; e.er = er;
    e.ack = ack; e.mr = mr; e.resp = resp; e.rdata = rdata; e.proto = proto;
    tbl.push_back(e);
  endtask

  task automatic set_in(input logic req, cmd, input logic [31:0] addr, input logic gnt, rv,
                        input logic [31:0] rd, input logic er);
    imem_req = req; imem_cmd = cmd; imem_addr = addr;
    mem_gnt = gnt; mem_rvalid = rv; mem_rdata = rd; mem_err = er;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(1'b1, 1'b0, 32'h00010000, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_ack", imem_req_ack, 0);
      chk("rst_mem_req", mem_req, 0);
      @(posedge clk); #1;
      chk("rst_resp", imem_resp, 0);
      chk("rst_rdata", imem_rdata, 0);
      chk("rst_proto", proto_err, 0);
    end
    rst = 1'b0;
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // Random-phase model state
  typedef struct { int ready; logic [31:0] data; logic err; } be_t;
  be_t         be_q[$];
  int          m_cnt;
  bit          m_errp;
  logic [1:0]  m_resp;
  logic [31:0] m_rdata;
  int          last_ready;

  function automatic bit is_lerr(input logic cmd, input logic [31:0] a);
    return cmd || (a % 4 != 0) || ((a & MASK) != PAT);
  endfunction

  initial begin
    rst = 1'b1;
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    @(posedge clk); #1;
    do_reset();

    // req cmd addr gnt rv rdata err | ack mem_req resp rdata proto (after edge)
    v(1,0,32'h00010004,1,0,32'h0,0,          1,1,2'b00,32'h0,0);
    v(0,0,32'h0,0,0,32'h0,0,                 0,0,2'b00,32'h0,0);
    v(0,0,32'h0,0,1,32'hDEADBEEF,0,          0,0,2'b01,32'hDEADBEEF,0);
    v(1,1,32'h00010000,0,0,32'h0,0,          1,0,2'b00,32'hDEADBEEF,0);
    v(1,0,32'h00010002,0,0,32'h0,0,          0,0,2'b10,32'h0,0);
    v(1,0,32'h00010002,0,0,32'h0,0,          1,0,2'b00,32'h0,0);
    v(1,0,32'h00020000,0,0,32'h0,0,          0,0,2'b10,32'h0,0);
    v(1,0,32'h00020000,0,0,32'h0,0,          1,0,2'b00,32'h0,0);
    v(0,0,32'h0,0,0,32'h0,0,                 0,0,2'b10,32'h0,0);
    v(1,0,32'h00010000,1,0,32'h0,0,          1,1,2'b00,32'h0,0);
    v(1,1,32'h00010000,1,0,32'h0,0,          0,0,2'b00,32'h0,0);
    v(1,1,32'h00010000,1,0,32'h0,0,          0,0,2'b00,32'h0,0);
    v(1,1,32'h00010000,1,1,32'h12345678,0,   0,0,2'b01,32'h12345678,0);
    v(1,1,32'h00010000,1,0,32'h0,0,          1,0,2'b00,32'h12345678,0);
    v(0,0,32'h0,0,0,32'h0,0,                 0,0,2'b10,32'h0,0);
    v(1,0,32'h00010008,1,0,32'h0,0,          1,1,2'b00,32'h0,0);
    v(0,0,32'h0,0,1,32'hFFFFFFFF,1,          0,0,2'b10,32'h0,0);
    v(0,0,32'h0,0,1,32'hCAFEF00D,0,          0,0,2'b00,32'h0,1);
    v(0,0,32'h0,0,0,32'h0,0,                 0,0,2'b00,32'h0,1);
    v(1,0,32'h0001000C,0,0,32'h0,0,          0,1,2'b00,32'h0,1);
    v(0,0,32'h0,0,0,32'h0,0,                 0,0,2'b00,32'h0,1);
    v(1,0,32'h00010000,1,0,32'h0,0,          1,1,2'b00,32'h0,1);
    v(1,0,32'h00010004,1,1,32'hA0A0A0A0,0,   1,1,2'b01,32'hA0A0A0A0,1);
    v(1,0,32'h00010008,1,1,32'hA1A1A1A1,0,   1,1,2'b01,32'hA1A1A1A1,1);
    v(0,0,32'h0,0,1,32'hA2A2A2A2,0,          0,0,2'b01,32'hA2A2A2A2,1);
    v(1,0,32'h00010010,1,0,32'h0,0,          1,1,2'b00,32'hA2A2A2A2,1);
    v(1,0,32'h00010014,1,0,32'h0,0,          1,1,2'b00,32'hA2A2A2A2,1);
    v(1,0,32'h00010018,1,0,32'h0,0,          0,0,2'b00,32'hA2A2A2A2,1);
    v(1,0,32'h00010018,1,1,32'hB0B0B0B0,0,   1,1,2'b01,32'hB0B0B0B0,1);
    v(0,0,32'h0,0,1,32'hB1B1B1B1,0,          0,0,2'b01,32'hB1B1B1B1,1);
    v(0,0,32'h0,0,1,32'hB2B2B2B2,0,          0,0,2'b01,32'hB2B2B2B2,1);

    foreach (tbl[i]) begin
      set_in(tbl[i].req, tbl[i].cmd, tbl[i].addr, tbl[i].gnt, tbl[i].rv, tbl[i].rd, tbl[i].er);
      @(negedge clk);
      chk($sformatf("v%0d_ack", i), imem_req_ack, tbl[i].ack);
      chk($sformatf("v%0d_mem_req", i), mem_req, tbl[i].mr);
      if (tbl[i].mr) chk($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].addr);
      @(posedge clk); #1;
      chk($sformatf("v%0d_resp", i), imem_resp, tbl[i].resp);
      chk($sformatf("v%0d_rdata", i), imem_rdata, tbl[i].rdata);
      chk($sformatf("v%0d_proto", i), proto_err, tbl[i].proto);
    end

    // proto_err is cleared by reset, and reset drops everything in flight
    do_reset();

    m_cnt = 0; m_errp = 0; m_resp = 2'b00; m_rdata = '0; last_ready = 0;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      logic        req, cmd, gnt, rv, rer, e_mr, e_ack, be_acc, err_acc, room;
      logic [31:0] addr, rd;
      int          lat;
      req = ($urandom_range(3) != 0);
      cmd = ($urandom_range(9) == 0);
      case ($urandom_range(9))
        0:       addr = $urandom;
        1:       addr = {16'h0001, 16'($urandom)};
        default: addr = {16'h0001, 14'($urandom), 2'b00};
      endcase
      gnt = ($urandom_range(3) != 0);
      rv = 0; rd = $urandom; rer = 0;
      if (be_q.size() != 0 && be_q[0].ready <= cyc) begin
        rv = 1; rd = be_q[0].data; rer = be_q[0].err;
      end
      set_in(req, cmd, addr, gnt, rv, rd, rer);

      room    = (m_cnt < OUTS) || (m_cnt == OUTS && rv);
      e_mr    = req && !is_lerr(cmd, addr) && !m_errp && room;
      be_acc  = e_mr && gnt;
      err_acc = req && is_lerr(cmd, addr) && !m_errp && m_cnt == 0 && !rv;
      e_ack   = be_acc || err_acc;

      @(negedge clk);
      chk("rnd_ack", imem_req_ack, e_ack);
      chk("rnd_mem_req", mem_req, e_mr);
      if (e_mr) chk("rnd_mem_addr", mem_addr, addr);
      if (m_cnt > OUTS) chk("rnd_cnt_bound", m_cnt, OUTS);

      if (rv && m_cnt != 0) begin
        m_resp  = rer ? 2'b10 : 2'b01;
        m_rdata = rer ? 32'h0 : rd;
        void'(be_q.pop_front());
        m_cnt--;
      end else if (m_errp) begin
        m_resp = 2'b10; m_rdata = '0; m_errp = 0;
      end else begin
        m_resp = 2'b00;
      end
      if (err_acc) m_errp = 1;
      if (be_acc) begin
        be_t b;
        lat = $urandom_range(1, 3);
        b.ready = (cyc + lat > last_ready + 1) ? cyc + lat : last_ready + 1;
        last_ready = b.ready;
        b.data = $urandom;
        b.err = ($urandom_range(7) == 0);
        be_q.push_back(b);
        m_cnt++;
      end

      @(posedge clk); #1;
      chk("rnd_resp", imem_resp, m_resp);
      chk("rnd_rdata", imem_rdata, m_rdata);
      chk("rnd_proto", proto_err, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/scr1_imem_responder.md
Name: scr1_imem_responder

Overview:
- Target-side endpoint of the SCR1 instruction-memory protocol: accepts imem requests (req/ack, then a single-cycle resp with rdata) and serves them from a pipelined read-only backend (e.g. a boot ROM or SRAM controller).
- Sits downstream of an imem port, either the core port or one routed port.
- Rejects writes, misaligned addresses and out-of-window addresses locally with an error response, without touching the backend.
- Tracks outstanding backend reads so that responses come back in order.

Parameters:
- SCR1_ADDR_MASK, 32'hffff0000, bits compared for window decode.
- SCR1_ADDR_PATTERN, 32'h00010000, required value of masked address.
- OUTSTANDING, 2, maximum backend reads in flight (1..7).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; synchronous and active-high.
- imem_req_ack  out  1  request accepted this cycle (combinational).
- imem_req  in  1  request valid.
- imem_cmd  in  1  0 = read, 1 = write.
- imem_addr  in  32  byte address.
- imem_rdata  out  32  read data, valid when imem_resp == 2'b01.
- imem_resp  out  2  00 idle, 01 ok, 10 error; single-cycle pulse per request.
- mem_req  out  1  backend read request.
- mem_addr  out  32  backend address = imem_addr.
- mem_gnt  in  1  backend accepts mem_req this cycle.
- mem_rvalid  in  1  backend read data returned (in order, at least 1 cycle after grant).
- mem_rdata  in  32  backend data.
- mem_err  in  1  backend error, qualified by mem_rvalid.
- proto_err  out  1  sticky: mem_rvalid seen with no read outstanding.

Behaviour:
- Reset (rst high at posedge): outstanding counter cnt = 0, err_pend = 0, imem_resp = 00, imem_rdata = 0, proto_err = 0. Any in-flight request is dropped. The backend shares rst, so no stale mem_rvalid is expected.
- Local error (lerr) = imem_cmd == 1, or imem_addr[1:0] != 0, or (imem_addr & SCR1_ADDR_MASK) != SCR1_ADDR_PATTERN.
- Counter width: $clog2(OUTSTANDING+1).
- Room = (cnt < OUTSTANDING) or (cnt == OUTSTANDING and mem_rvalid). A same-cycle retire frees the slot.
- Backend path:
  - mem_req = imem_req & ~lerr & ~err_pend & room & ~rst.
  - imem_req_ack = mem_req & mem_gnt.
- Error path:
  - imem_req_ack = imem_req & lerr & ~err_pend & (cnt == 0) & ~mem_rvalid & ~rst.
  - On ack, err_pend is set.
  - Error and backend traffic never overlap, so ordering is trivially preserved.
- Counter update each cycle: cnt += (backend ack) − (mem_rvalid & cnt != 0). Simultaneous accept and retire leaves cnt unchanged.
- Response register (one per cycle, priority order):
  1. mem_rvalid & cnt != 0: imem_resp = mem_err ? 10 : 01; imem_rdata = mem_rdata (0 on error).
  2. Else if err_pend: imem_resp = 10, imem_rdata = 0, err_pend cleared.
  3. Else: imem_resp = 00 and imem_rdata holds its value.
- Latency:
  - Backend read: ack at T, data at R ≥ T+1, imem_resp visible R+1.
  - Local error: ack at T, imem_resp = 10 at T+1.
  - Back-to-back errors: one every 2 cycles.
- Throughput: one backend read per cycle when OUTSTANDING ≥ backend latency + 1.
- Spurious response: mem_rvalid with cnt == 0 sets proto_err (until rst), is otherwise ignored, and produces no imem_resp.
- A requester dropping imem_req before ack is legal; there are no side effects.

Test Plan:
- Reset: hold rst for 2 cycles with imem_req = 1 → imem_req_ack = 0, mem_req = 0, imem_resp = 00, proto_err = 0.
- Single read:
  - Stimulus: addr 32'h00010004, mem_gnt = 1, backend returns 32'hDEADBEEF 2 cycles later.
  - Required: ack at T, mem_addr = 32'h00010004, imem_resp = 01 with rdata DEADBEEF at T+3.
- Pipelined reads:
  - Stimulus: addresses 0x10000, 0x10004, 0x10008 back-to-back; backend latency 1; OUTSTANDING = 2.
  - Required: acks in 3 consecutive cycles; responses 01 in order with matching data; cnt never exceeds 2.
- Local errors:
  - Stimulus: a write to 0x10000, then a read at 0x10002, then a read at 0x20000.
  - Required: each acked, mem_req stays 0, imem_resp = 10 the following cycle; consecutive errors spaced 2 cycles apart.
- Mixed ordering:
  - Stimulus: read 0x10000 (backend latency 3) followed immediately by a write.
  - Required: the write is not acked until the read response retires; the 01 response precedes the 10 response.
- Backend error and spurious response:
  - Stimulus: mem_rvalid with mem_err = 1 for an outstanding read, then mem_rvalid with cnt == 0.
  - Required: imem_resp = 10 with rdata 0 for the read; proto_err goes to 1 and stays set until rst.
